// File: rtl/i2s_rx.sv
// I2S capture receiver: synchronizes SCLK/LRCLK/SDATA into clk_100M, deserializes
// MSB-first left/right words and hands completed pairs out through valid/ready.
module i2s_rx #(
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned SLOT_BITS   = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_100M,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  lrclk,
   input  logic                  sdata,
   output logic [DATA_WIDTH-1:0] left_data,
   output logic [DATA_WIDTH-1:0] right_data,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam int unsigned CNT_MAX = SLOT_BITS + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_DW  = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] lrclk_sync_q;
   logic [SYNC_STAGES-1:0] sdata_sync_q;
   logic                   sclk_d_q;
   logic                   sclk_s;
   logic                   lrclk_s;
   logic                   sdata_s;
   logic                   sclk_rise;

   state_t                 state_q, state_d;
   logic                   lr_prev_q, lr_prev_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic [DATA_WIDTH-1:0]  left_hold_q, left_hold_d;
   logic                   left_ok_q, left_ok_d;
   logic [DATA_WIDTH-1:0]  left_data_q, left_data_d;
   logic [DATA_WIDTH-1:0]  right_data_q, right_data_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;
   logic                   frame_err_q, frame_err_d;
   logic                   pair_done;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
   assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d_q;

   // All three lines share the same chain depth so lrclk/sdata line up with the sclk edge.
   always_ff @(posedge clk_100M) begin
      if (!rst) begin
         sclk_sync_q  <= '0;
         lrclk_sync_q <= '0;
         sdata_sync_q <= '0;
         sclk_d_q     <= 1'b0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
         sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
         sclk_d_q     <= sclk_s;
      end
   end

   always_ff @(posedge clk_100M) begin
      if (!rst) begin
         state_q <= WAIT_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_100M) begin
      if (!rst) begin
         lr_prev_q    <= 1'b0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         left_hold_q  <= '0;
         left_ok_q    <= 1'b0;
         left_data_q  <= '0;
         right_data_q <= '0;
         valid_q      <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         lr_prev_q    <= lr_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         left_hold_q  <= left_hold_d;
         left_ok_q    <= left_ok_d;
         left_data_q  <= left_data_d;
         right_data_q <= right_data_d;
         valid_q      <= valid_d;
         overrun_q    <= overrun_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      lr_prev_d    = lr_prev_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      left_hold_d  = left_hold_q;
      left_ok_d    = left_ok_q;
      left_data_d  = left_data_q;
      right_data_d = right_data_q;
      valid_d      = valid_q;
      overrun_d    = 1'b0;
      frame_err_d  = 1'b0;
      pair_done    = 1'b0;

      if (valid_q && sample_ready) begin
         valid_d = 1'b0;
      end

      if (sclk_rise) begin
         if (lrclk_s != lr_prev_q) begin
            // Boundary rise: its data bit is the I2S one-bit delay and is dropped.
            if (state_q != WAIT_SYNC && bit_cnt_q < CNT_DW) begin
               frame_err_d = 1'b1;
               left_ok_d   = 1'b0;
            end
            lr_prev_d = lrclk_s;
            bit_cnt_d = '0;
            shift_d   = '0;
            unique case (state_q)
               WAIT_SYNC: state_d = lrclk_s ? WAIT_SYNC : LEFT;
               LEFT:      state_d = RIGHT;
               RIGHT:     state_d = LEFT;
               default:   state_d = WAIT_SYNC;
            endcase
         end else if (bit_cnt_q < CNT_DW) begin
            shift_d   = {shift_q[DATA_WIDTH-2:0], sdata_s};
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            if (bit_cnt_d == CNT_DW) begin
               if (state_q == LEFT) begin
                  left_hold_d = shift_d;
                  left_ok_d   = 1'b1;
               end else if (state_q == RIGHT && left_ok_q) begin
                  pair_done = 1'b1;
                  left_ok_d = 1'b0;
               end
            end
         end else if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            if (bit_cnt_d == CNT_SAT && state_q != WAIT_SYNC) begin
               frame_err_d = 1'b1;
            end
         end
      end

      // A same-cycle acceptance frees the output register for the new pair.
      if (pair_done) begin
         if (!valid_q || sample_ready) begin
            left_data_d  = left_hold_q;
            right_data_d = shift_d;
            valid_d      = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign left_data    = left_data_q;
   assign right_data   = right_data_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S slots at clk/8 and checks delivered pairs and error
// pulses against a slot-level reference model.
module tb_i2s_rx;

   localparam int W  = 24;
   localparam int SB = 32;

   logic         clk_100M = 1'b0;
   logic         rst = 1'b0;
   logic         sclk = 1'b0;
   logic         lrclk = 1'b0;
   logic         sdata = 1'b0;
   logic         sample_ready = 1'b0;
   logic [W-1:0] left_data;
   logic [W-1:0] right_data;
   logic         sample_valid;
   logic         overrun;
   logic         frame_err;

   i2s_rx #(.DATA_WIDTH(W), .SLOT_BITS(SB), .SYNC_STAGES(2)) dut (
      .clk_100M     (clk_100M),
      .rst          (rst),
      .sclk         (sclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .left_data    (left_data),
      .right_data   (right_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   always #5 clk_100M = ~clk_100M;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // DUT observation
   logic [2*W-1:0] got_q[$];
   int unsigned    got_ovr  = 0;
   int unsigned    got_ferr = 0;
   int unsigned    sim_drop = 0;
   bit             sim_watch = 1'b0;

   always @(negedge clk_100M) begin
      if (rst && sample_valid && sample_ready) got_q.push_back({left_data, right_data});
      if (overrun) got_ovr++;
      if (frame_err) got_ferr++;
      if (sim_watch && !sample_valid) sim_drop++;
   end

   // Slot-level reference model
   logic [2*W-1:0] exp_q[$];
   int             m_st;     // 0 unsynced, 1 in left slot, 2 in right slot
   int             m_cnt;
   bit             m_lr, m_lok, m_valid;
   logic [W-1:0]   m_left;
   logic [2*W-1:0] m_hold;
   int unsigned    m_ovr  = 0;
   int unsigned    m_ferr = 0;

   task automatic model_reset();
      m_st = 0; m_cnt = 0; m_lr = 1'b0; m_lok = 1'b0; m_valid = 1'b0;
   endtask

   task automatic model_slot(input bit lr, input int n, input logic [W-1:0] word, input bit pulse);
      logic [2*W-1:0] pr;
      if (lr == m_lr) begin
         m_cnt += n + 1;
         return;
      end
      if (m_st != 0 && m_cnt < W) begin
         m_ferr++;
         m_lok = 1'b0;
      end
      if (!lr) m_st = 1;
      else     m_st = (m_st == 1) ? 2 : 0;
      m_lr  = lr;
      m_cnt = n;
      if (m_st == 0) return;
      if (n >= W) begin
         if (m_st == 1) begin
            m_left = word;
            m_lok  = 1'b1;
         end else if (m_lok) begin
            m_lok = 1'b0;
            pr = {m_left, word};
            if (m_valid && !(pulse || sample_ready)) m_ovr++;
            else begin
               if (m_valid) exp_q.push_back(m_hold);
               if (sample_ready) begin
                  exp_q.push_back(pr);
                  m_valid = 1'b0;
               end else begin
                  m_hold  = pr;
                  m_valid = 1'b1;
               end
            end
         end
      end
      if (n >= SB + 1) m_ferr++;
   endtask

   task automatic tick();
      @(posedge clk_100M);
      #1;
   endtask

   task automatic send_bit(input bit lr, input bit d, input bit pulse);
      lrclk = lr;
      sdata = d;
      repeat (4) tick();
      sclk = 1'b1;
      tick();
      tick();
      if (pulse) sample_ready = 1'b1;
      tick();
      if (pulse) sample_ready = 1'b0;
      tick();
      sclk = 1'b0;
   endtask

   task automatic send_slot(input bit lr, input int n, input logic [W-1:0] word, input bit pulse);
      bit b;
      send_bit(lr, 1'($urandom), 1'b0);
      for (int i = 0; i < n; i++) begin
         b = (i < W) ? word[W-1-i] : 1'($urandom);
         send_bit(lr, b, pulse && (i == W - 1));
      end
      model_slot(lr, n, word, pulse);
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
      send_slot(1'b0, 31, l, 1'b0);
      send_slot(1'b1, 31, r, 1'b0);
   endtask

   task automatic set_ready(input bit v);
      sample_ready = v;
      if (v && m_valid) begin
         exp_q.push_back(m_hold);
         m_valid = 1'b0;
      end
      tick();
   endtask

   task automatic compare_all(input string tag);
      tick();
      tick();
      check({tag, "/pairs"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "/pair"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
      got_q.delete();
      exp_q.delete();
      check({tag, "/overrun"}, 64'(got_ovr), 64'(m_ovr));
      check({tag, "/frame_err"}, 64'(got_ferr), 64'(m_ferr));
   endtask

   function automatic int rand_len();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return int'($urandom_range(8, W - 1));
      if (r == 1) return SB + 1;
      if (r == 2) return int'($urandom_range(W, 30));
      return 31;
   endfunction

   logic [W-1:0] a_l, a_r, b_l, b_r;
   int unsigned  ferr0;

   initial begin
      model_reset();
      repeat (3) tick();
      check("rst/left", 64'(left_data), 64'h0);
      check("rst/right", 64'(right_data), 64'h0);
      check("rst/valid", 64'(sample_valid), 64'h0);
      check("rst/overrun", 64'(overrun), 64'h0);
      check("rst/frame_err", 64'(frame_err), 64'h0);
      rst = 1'b1;
      tick();

      // nominal
      set_ready(1'b1);
      send_slot(1'b1, 31, W'($urandom), 1'b0);
      send_frame(24'hA5C3F1, 24'h5A3C0F);
      send_frame(24'hA5C3F1, 24'h5A3C0F);
      compare_all("nominal");

      // sync start: reset released part way through a right slot
      rst = 1'b0;
      repeat (3) send_bit(1'b1, 1'($urandom), 1'b0);
      rst = 1'b1;
      model_reset();
      send_slot(1'b1, 9, W'($urandom), 1'b0);
      check("sync/novalid", 64'(sample_valid), 64'h0);
      send_frame(24'h123456, 24'h654321);
      compare_all("sync");

      // backpressure over three frames
      set_ready(1'b0);
      a_l = W'($urandom); a_r = W'($urandom);
      send_frame(a_l, a_r);
      check("bp/valid", 64'(sample_valid), 64'h1);
      send_frame(W'($urandom), W'($urandom));
      send_frame(W'($urandom), W'($urandom));
      check("bp/hold_valid", 64'(sample_valid), 64'h1);
      check("bp/hold_pair", 64'({left_data, right_data}), 64'({a_l, a_r}));
      set_ready(1'b1);
      check("bp/drop_valid", 64'(sample_valid), 64'h0);
      compare_all("bp");

      // ready asserted exactly in the completion cycle
      set_ready(1'b0);
      send_frame(W'($urandom), W'($urandom));
      b_l = W'($urandom); b_r = W'($urandom);
      sim_watch = 1'b1;
      send_slot(1'b0, 31, b_l, 1'b0);
      send_slot(1'b1, 31, b_r, 1'b1);
      sim_watch = 1'b0;
      check("sim/valid_gap", 64'(sim_drop), 64'h0);
      check("sim/new_pair", 64'({left_data, right_data}), 64'({b_l, b_r}));
      set_ready(1'b1);
      compare_all("sim");

      // short left slot
      ferr0 = got_ferr;
      send_slot(1'b0, 16, W'($urandom), 1'b0);
      send_slot(1'b1, 31, 24'h0000FF, 1'b0);
      check("short/ferr_once", 64'(got_ferr - ferr0), 64'h1);
      send_frame(W'($urandom), W'($urandom));
      compare_all("short");

      // randomized slot lengths, data and readiness
      for (int f = 0; f < 16; f++) begin
         if ($urandom_range(0, 3) == 0) set_ready(1'($urandom));
         send_slot(1'b0, rand_len(), W'($urandom), 1'b0);
         send_slot(1'b1, rand_len(), W'($urandom), 1'b0);
      end
      set_ready(1'b1);
      send_frame(W'($urandom), W'($urandom));
      compare_all("random");

      // reset at bit 10 of a left slot while a pair is pending
      set_ready(1'b0);
      send_frame(W'($urandom), W'($urandom));
      check("rstmid/valid_before", 64'(sample_valid), 64'h1);
      send_bit(1'b0, 1'($urandom), 1'b0);
      repeat (10) send_bit(1'b0, 1'($urandom), 1'b0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      model_reset();
      check("rstmid/outs", 64'({left_data, right_data, sample_valid, overrun, frame_err}), 64'h0);
      repeat (21) send_bit(1'b0, 1'($urandom), 1'b0);
      set_ready(1'b1);
      send_slot(1'b1, 31, W'($urandom), 1'b0);
      send_frame(W'($urandom), W'($urandom));
      compare_all("rstmid");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
